// File: rtl/itlb_tag_cam.sv
// Fully-associative Sv32 ITLB tag CAM: registered lookup, fill with victim selection, SFENCE.VMA invalidation.
// Build option: define ITLB_PLRU_EN for tree pseudo-LRU replacement; the default is a round-robin pointer.
module itlb_tag_cam #(
  parameter int ENTRY_NUM = 8,
  parameter int ASID_WD   = 9,
  parameter int VPN1_WD   = 10,
  parameter int VPN0_WD   = 10,
  localparam int IDX_WD   = $clog2(ENTRY_NUM),
  localparam int VPN_WD   = VPN1_WD + VPN0_WD
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 lkup_valid_i,
  input  logic [ASID_WD-1:0]   lkup_asid_i,
  input  logic [VPN_WD-1:0]    lkup_vpn_i,
  output logic                 lkup_hit_o,
  output logic [ENTRY_NUM-1:0] lkup_hit_vec_o,
  output logic [IDX_WD-1:0]    lkup_hit_idx_o,
  input  logic                 fill_valid_i,
  output logic                 fill_ready_o,
  input  logic [ASID_WD-1:0]   fill_asid_i,
  input  logic [VPN_WD-1:0]    fill_vpn_i,
  input  logic                 fill_g_i,
  input  logic                 fill_mega_i,
  output logic [IDX_WD-1:0]    fill_idx_o,
  output logic                 fill_done_o,
  input  logic                 sfence_valid_i,
  input  logic                 sfence_rs1_z_i,
  input  logic                 sfence_rs2_z_i,
  input  logic [ASID_WD-1:0]   sfence_asid_i,
  input  logic [VPN_WD-1:0]    sfence_vpn_i,
  output logic                 sfence_done_o
);

  logic [ENTRY_NUM-1:0]              v_q, v_d, g_q, g_d, mega_q, mega_d;
  logic [ENTRY_NUM-1:0][ASID_WD-1:0] asid_q, asid_d;
  logic [ENTRY_NUM-1:0][VPN_WD-1:0]  vpn_q, vpn_d;

  logic                 lkup_hit_q, lkup_hit_d;
  logic [ENTRY_NUM-1:0] lkup_hit_vec_q, lkup_hit_vec_d;
  logic [IDX_WD-1:0]    lkup_hit_idx_q, lkup_hit_idx_d;
  logic [IDX_WD-1:0]    fill_idx_q, fill_idx_d;
  logic                 fill_done_q, fill_done_d;
  logic                 sfence_done_q, sfence_done_d;

  logic [ENTRY_NUM-1:0] lkup_vec_s, fill_vec_s, sf_clr_s;
  logic                 fill_fire_s, fill_exist_s, inv_found_s;
  logic [IDX_WD-1:0]    inv_idx_s, victim_idx_s, tgt_idx_s;

  function automatic logic vpn_match(input logic mega, input logic [VPN_WD-1:0] e_vpn,
                                     input logic [VPN_WD-1:0] vpn);
    return (vpn[VPN_WD-1:VPN0_WD] == e_vpn[VPN_WD-1:VPN0_WD]) &
           (mega | (vpn[VPN0_WD-1:0] == e_vpn[VPN0_WD-1:0]));
  endfunction

  function automatic logic tag_match(input logic v, input logic g, input logic mega,
                                     input logic [ASID_WD-1:0] e_asid, input logic [ASID_WD-1:0] asid,
                                     input logic [VPN_WD-1:0] e_vpn, input logic [VPN_WD-1:0] vpn);
    return v & (g | (asid == e_asid)) & vpn_match(mega, e_vpn, vpn);
  endfunction

  // Hit vectors are one-hot (fills overwrite matching entries), so OR-encoding is exact.
  function automatic logic [IDX_WD-1:0] onehot_enc(input logic [ENTRY_NUM-1:0] vec);
    logic [IDX_WD-1:0] idx;
    idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      idx = vec[i] ? (idx | IDX_WD'(i)) : idx;
    end
    return idx;
  endfunction

  // Per-entry match against lookup, fill and sfence operands.
  always_comb begin
    lkup_vec_s = '0;
    fill_vec_s = '0;
    sf_clr_s   = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
      lkup_vec_s[e] = tag_match(v_q[e], g_q[e], mega_q[e], asid_q[e], lkup_asid_i, vpn_q[e], lkup_vpn_i);
      fill_vec_s[e] = tag_match(v_q[e], g_q[e], mega_q[e], asid_q[e], fill_asid_i, vpn_q[e], fill_vpn_i);
      case ({sfence_rs1_z_i, sfence_rs2_z_i})
        2'b11:   sf_clr_s[e] = 1'b1;
        2'b10:   sf_clr_s[e] = ~g_q[e] & (sfence_asid_i == asid_q[e]);
        2'b01:   sf_clr_s[e] = vpn_match(mega_q[e], vpn_q[e], sfence_vpn_i);
        default: sf_clr_s[e] = vpn_match(mega_q[e], vpn_q[e], sfence_vpn_i) &
                               ~g_q[e] & (sfence_asid_i == asid_q[e]);
      endcase
    end
  end

  // Fill target: existing match, else lowest invalid entry, else replacement victim.
  always_comb begin
    fill_fire_s  = fill_valid_i & ~sfence_valid_i;
    fill_exist_s = |fill_vec_s;
    inv_found_s  = ~&v_q;
    inv_idx_s    = '0;
    for (int e = ENTRY_NUM - 1; e >= 0; e--) begin
      inv_idx_s = v_q[e] ? inv_idx_s : IDX_WD'(e);
    end
    tgt_idx_s = fill_exist_s ? onehot_enc(fill_vec_s) : (inv_found_s ? inv_idx_s : victim_idx_s);
  end

`ifdef ITLB_PLRU_EN
  logic [ENTRY_NUM-2:0] plru_q, plru_d;

  // Heap-ordered tree: node n (root n=1) lives at bit n-1; a bit set to 1 steers the victim right.
  function automatic logic [IDX_WD-1:0] plru_victim(input logic [ENTRY_NUM-2:0] tree);
    int node;
    node = 1;
    for (int lvl = 0; lvl < IDX_WD; lvl++) begin
      node = 2 * node + int'(tree[node-1]);
    end
    return IDX_WD'(node - ENTRY_NUM);
  endfunction

  function automatic logic [ENTRY_NUM-2:0] plru_touch(input logic [ENTRY_NUM-2:0] tree,
                                                      input logic [IDX_WD-1:0] idx);
    logic [ENTRY_NUM-2:0] t;
    int                   node;
    t    = tree;
    node = 1;
    for (int lvl = 0; lvl < IDX_WD; lvl++) begin
      t[node-1] = ~idx[IDX_WD-1-lvl];
      node      = 2 * node + int'(idx[IDX_WD-1-lvl]);
    end
    return t;
  endfunction

  // Touch order: registered lookup hit first, then the fill target as the most recent use.
  always_comb begin
    victim_idx_s = plru_victim(plru_q);
    plru_d       = lkup_hit_q ? plru_touch(plru_q, lkup_hit_idx_q) : plru_q;
    plru_d       = fill_fire_s ? plru_touch(plru_d, tgt_idx_s) : plru_d;
  end

  // Pseudo-LRU tree register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      plru_q <= '0;
    end else begin
      plru_q <= plru_d;
    end
  end
`else
  logic [IDX_WD-1:0] rr_ptr_q, rr_ptr_d;
  logic              use_victim_s;

  // Pointer advances only when a fill actually evicts the victim.
  always_comb begin
    victim_idx_s = rr_ptr_q;
    use_victim_s = fill_fire_s & ~fill_exist_s & ~inv_found_s;
    rr_ptr_d     = use_victim_s ? (rr_ptr_q + IDX_WD'(1)) : rr_ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Entry state update: sfence wins over fill.
  always_comb begin
    v_d    = v_q;
    g_d    = g_q;
    mega_d = mega_q;
    asid_d = asid_q;
    vpn_d  = vpn_q;
    if (sfence_valid_i) begin
      v_d = v_q & ~sf_clr_s;
    end else if (fill_fire_s) begin
      v_d[tgt_idx_s]    = 1'b1;
      g_d[tgt_idx_s]    = fill_g_i;
      mega_d[tgt_idx_s] = fill_mega_i;
      asid_d[tgt_idx_s] = fill_asid_i;
      vpn_d[tgt_idx_s]  = fill_vpn_i;
    end else begin
      v_d = v_q;
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    lkup_hit_d     = lkup_valid_i & (|lkup_vec_s);
    lkup_hit_vec_d = lkup_valid_i ? lkup_vec_s : '0;
    lkup_hit_idx_d = lkup_valid_i ? onehot_enc(lkup_vec_s) : '0;
    fill_done_d    = fill_fire_s;
    fill_idx_d     = fill_fire_s ? tgt_idx_s : fill_idx_q;
    sfence_done_d  = sfence_valid_i;
  end

  // CAM contents and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v_q            <= '0;
      g_q            <= '0;
      mega_q         <= '0;
      asid_q         <= '0;
      vpn_q          <= '0;
      lkup_hit_q     <= 1'b0;
      lkup_hit_vec_q <= '0;
      lkup_hit_idx_q <= '0;
      fill_idx_q     <= '0;
      fill_done_q    <= 1'b0;
      sfence_done_q  <= 1'b0;
    end else begin
      v_q            <= v_d;
      g_q            <= g_d;
      mega_q         <= mega_d;
      asid_q         <= asid_d;
      vpn_q          <= vpn_d;
      lkup_hit_q     <= lkup_hit_d;
      lkup_hit_vec_q <= lkup_hit_vec_d;
      lkup_hit_idx_q <= lkup_hit_idx_d;
      fill_idx_q     <= fill_idx_d;
      fill_done_q    <= fill_done_d;
      sfence_done_q  <= sfence_done_d;
    end
  end

  assign fill_ready_o   = ~sfence_valid_i;
  assign lkup_hit_o     = lkup_hit_q;
  assign lkup_hit_vec_o = lkup_hit_vec_q;
  assign lkup_hit_idx_o = lkup_hit_idx_q;
  assign fill_idx_o     = fill_idx_q;
  assign fill_done_o    = fill_done_q;
  assign sfence_done_o  = sfence_done_q;

endmodule

// File: tb/tb_itlb_tag_cam.sv
// Scoreboard bench for itlb_tag_cam: directed stimulus pushes expectations, a monitor pops and compares.
module tb_itlb_tag_cam;

`ifdef ITLB_PLRU_EN
  localparam logic PLRU = 1'b1;
`else
  localparam logic PLRU = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        lkup_valid_i;
  logic [8:0]  lkup_asid_i;
  logic [19:0] lkup_vpn_i;
  logic        lkup_hit_o;
  logic [7:0]  lkup_hit_vec_o;
  logic [2:0]  lkup_hit_idx_o;
  logic        fill_valid_i;
  logic        fill_ready_o;
  logic [8:0]  fill_asid_i;
  logic [19:0] fill_vpn_i;
  logic        fill_g_i;
  logic        fill_mega_i;
  logic [2:0]  fill_idx_o;
  logic        fill_done_o;
  logic        sfence_valid_i;
  logic        sfence_rs1_z_i;
  logic        sfence_rs2_z_i;
  logic [8:0]  sfence_asid_i;
  logic [19:0] sfence_vpn_i;
  logic        sfence_done_o;

  itlb_tag_cam dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .lkup_valid_i(lkup_valid_i), .lkup_asid_i(lkup_asid_i), .lkup_vpn_i(lkup_vpn_i),
    .lkup_hit_o(lkup_hit_o), .lkup_hit_vec_o(lkup_hit_vec_o), .lkup_hit_idx_o(lkup_hit_idx_o),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_asid_i(fill_asid_i),
    .fill_vpn_i(fill_vpn_i), .fill_g_i(fill_g_i), .fill_mega_i(fill_mega_i),
    .fill_idx_o(fill_idx_o), .fill_done_o(fill_done_o),
    .sfence_valid_i(sfence_valid_i), .sfence_rs1_z_i(sfence_rs1_z_i), .sfence_rs2_z_i(sfence_rs2_z_i),
    .sfence_asid_i(sfence_asid_i), .sfence_vpn_i(sfence_vpn_i), .sfence_done_o(sfence_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic hit; logic [2:0] idx; } lk_exp_t;
  typedef struct packed { logic [2:0] idx; logic ne0; } fl_exp_t;

  lk_exp_t lk_q[$];
  fl_exp_t fl_q[$];
  int      sf_pend = 0;
  int      n_cmp   = 0;
  int      n_err   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lk(input logic [8:0] asid, input logic [19:0] vpn, input logic hit, input logic [2:0] idx);
    lkup_valid_i = 1'b1;
    lkup_asid_i  = asid;
    lkup_vpn_i   = vpn;
    lk_q.push_back('{hit, idx});
  endtask

  task automatic fl(input logic [8:0] asid, input logic [19:0] vpn, input logic g, input logic mega,
                    input logic [2:0] idx, input logic ne0);
    fill_valid_i = 1'b1;
    fill_asid_i  = asid;
    fill_vpn_i   = vpn;
    fill_g_i     = g;
    fill_mega_i  = mega;
    fl_q.push_back('{idx, ne0});
  endtask

  task automatic sf(input logic rs1z, input logic rs2z, input logic [8:0] asid, input logic [19:0] vpn);
    sfence_valid_i = 1'b1;
    sfence_rs1_z_i = rs1z;
    sfence_rs2_z_i = rs2z;
    sfence_asid_i  = asid;
    sfence_vpn_i   = vpn;
    sf_pend++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    lkup_valid_i   = 1'b0;
    fill_valid_i   = 1'b0;
    sfence_valid_i = 1'b0;
  endtask

  // Monitor: capture what the DUT sampled at posedge, check its registered response at negedge.
  initial begin
    logic    lk_pend;
    lk_exp_t le;
    fl_exp_t fe;
    logic [7:0] ev;
    forever begin
      @(posedge clk_i);
      lk_pend = lkup_valid_i & rstn_i;
      @(negedge clk_i);
      if (lk_pend) begin
        if (lk_q.size() == 0) begin
          chk("lookup_unexpected", 32'd1, 32'd0);
        end else begin
          le = lk_q.pop_front();
          ev = le.hit ? (8'd1 << le.idx) : 8'd0;
          chk("lookup{hit,vec,idx}", {20'd0, lkup_hit_o, lkup_hit_vec_o, lkup_hit_idx_o},
              {20'd0, le.hit, ev, (le.hit ? le.idx : 3'd0)});
        end
      end
      if (fill_done_o) begin
        if (fl_q.size() == 0) begin
          chk("fill_done_unexpected", 32'd1, 32'd0);
        end else begin
          fe = fl_q.pop_front();
          if (fe.ne0) chk("fill_idx_nonzero", {31'd0, fill_idx_o != 3'd0}, 32'd1);
          else        chk("fill_idx", {29'd0, fill_idx_o}, {29'd0, fe.idx});
        end
      end
      if (sfence_done_o) begin
        chk("sfence_done_expected", {31'd0, sf_pend > 0}, 32'd1);
        if (sf_pend > 0) sf_pend--;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    rstn_i = 1'b0;
    lkup_valid_i = 1'b0; lkup_asid_i = '0; lkup_vpn_i = '0;
    fill_valid_i = 1'b0; fill_asid_i = '0; fill_vpn_i = '0; fill_g_i = 1'b0; fill_mega_i = 1'b0;
    sfence_valid_i = 1'b0; sfence_rs1_z_i = 1'b0; sfence_rs2_z_i = 1'b0;
    sfence_asid_i = '0; sfence_vpn_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs", {18'd0, lkup_hit_o, lkup_hit_vec_o, lkup_hit_idx_o, fill_idx_o, fill_done_o, sfence_done_o},
        32'd0);
    chk("reset_fill_ready", {31'd0, fill_ready_o}, 32'd1);
    @(posedge clk_i);
    #1 rstn_i = 1'b1;

    // Miss on empty CAM; lookup + fill same cycle still misses; then hit.
    lk(9'd1, 20'h12345, 1'b0, 3'd0); tick();
    lk(9'd1, 20'h12345, 1'b0, 3'd0); fl(9'd1, 20'h12345, 1'b0, 1'b0, 3'd0, 1'b0);
    #1 chk("fill_ready_idle", {31'd0, fill_ready_o}, 32'd1);
    tick();
    lk(9'd1, 20'h12345, 1'b1, 3'd0); tick();

    // Fill the CAM, touch entry 0, then force two evictions.
    for (int i = 1; i < 8; i++) begin
      fl(9'd1, 20'(i), 1'b0, 1'b0, 3'(i), 1'b0); tick();
    end
    lk(9'd1, 20'h00003, 1'b1, 3'd3); tick();
    lk(9'd1, 20'h12345, 1'b1, 3'd0); tick(); tick(); tick();
    fl(9'd1, 20'h00100, 1'b0, 1'b0, 3'd0, PLRU); tick();
    fl(9'd1, 20'h00101, 1'b0, 1'b0, 3'd1, PLRU); tick();
`ifndef ITLB_PLRU_EN
    lk(9'd1, 20'h00100, 1'b1, 3'd0); tick();
    lk(9'd1, 20'h00101, 1'b1, 3'd1); tick();
    lk(9'd1, 20'h12345, 1'b0, 3'd0); tick();
`endif
    sf(1'b1, 1'b1, 9'd0, 20'd0); tick();
    lk(9'd1, 20'h00100, 1'b0, 3'd0); tick();
    lk(9'd1, 20'h00005, 1'b0, 3'd0); tick();

    // Global entry survives ASID sfence, dies on VPN sfence; ASID-selective invalidation.
    fl(9'd3, 20'h00A00, 1'b1, 1'b0, 3'd0, 1'b0); tick();
    lk(9'd5, 20'h00A00, 1'b1, 3'd0); tick();
    sf(1'b1, 1'b0, 9'd3, 20'd0); tick();
    lk(9'd5, 20'h00A00, 1'b1, 3'd0); tick();
    sf(1'b0, 1'b1, 9'd0, 20'h00A00); tick();
    lk(9'd5, 20'h00A00, 1'b0, 3'd0); tick();
    fl(9'd3, 20'h00B00, 1'b0, 1'b0, 3'd0, 1'b0); tick();
    fl(9'd4, 20'h00B00, 1'b0, 1'b0, 3'd1, 1'b0); tick();
    lk(9'd5, 20'h00B00, 1'b0, 3'd0); tick();
    sf(1'b1, 1'b0, 9'd3, 20'd0); tick();
    lk(9'd3, 20'h00B00, 1'b0, 3'd0); tick();
    lk(9'd4, 20'h00B00, 1'b1, 3'd1); tick();
    sf(1'b0, 1'b0, 9'd4, 20'h00B00); tick();
    lk(9'd4, 20'h00B00, 1'b0, 3'd0); tick();

    // Megapage ignores VPN0 on lookup and sfence; a 4 KiB page does not.
    fl(9'd2, 20'h00400, 1'b0, 1'b1, 3'd0, 1'b0); tick();
    lk(9'd2, 20'h007FF, 1'b1, 3'd0); tick();
    lk(9'd2, 20'h00800, 1'b0, 3'd0); tick();
    sf(1'b0, 1'b1, 9'd0, 20'h0040F); tick();
    lk(9'd2, 20'h00400, 1'b0, 3'd0); tick();
    fl(9'd2, 20'h00400, 1'b0, 1'b0, 3'd0, 1'b0); tick();
    lk(9'd2, 20'h007FF, 1'b0, 3'd0); tick();
    lk(9'd2, 20'h00400, 1'b1, 3'd0); tick();

    // Sfence blocks a same-cycle fill; refills reuse the matching entry.
    sf(1'b0, 1'b1, 9'd0, 20'hFFFFF);
    fill_valid_i = 1'b1; fill_asid_i = 9'd2; fill_vpn_i = 20'h00C00; fill_g_i = 1'b0; fill_mega_i = 1'b0;
    #1 chk("fill_ready_during_sfence", {31'd0, fill_ready_o}, 32'd0);
    tick();
    lk(9'd2, 20'h00C00, 1'b0, 3'd0); tick();
    fl(9'd2, 20'h00400, 1'b0, 1'b0, 3'd0, 1'b0); tick();
    lk(9'd2, 20'h00400, 1'b1, 3'd0); tick();
    fl(9'd2, 20'h00500, 1'b0, 1'b0, 3'd1, 1'b0); tick();
    fl(9'd2, 20'h00500, 1'b0, 1'b0, 3'd1, 1'b0); tick();
    lk(9'd2, 20'h00500, 1'b1, 3'd1); tick();
    tick();

    // Reset lands while a fill is in flight.
    fill_valid_i = 1'b1; fill_asid_i = 9'd2; fill_vpn_i = 20'h00600;
    @(negedge clk_i);
    #1 rstn_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("reset_fill_done", {31'd0, fill_done_o}, 32'd0);
    chk("reset_hit_and_idx", {27'd0, lkup_hit_o, fill_idx_o, sfence_done_o}, 32'd0);
    fill_valid_i = 1'b0;
    @(posedge clk_i);
    #1 rstn_i = 1'b1;
    lk(9'd2, 20'h00400, 1'b0, 3'd0); tick();
    lk(9'd2, 20'h00500, 1'b0, 3'd0); tick();
    lk(9'd2, 20'h00600, 1'b0, 3'd0); tick();
    fl(9'd2, 20'h00600, 1'b0, 1'b0, 3'd0, 1'b0); tick();
    lk(9'd2, 20'h00600, 1'b1, 3'd0); tick();
    repeat (3) tick();

    chk("lookup_queue_drained", lk_q.size(), 32'd0);
    chk("fill_queue_drained", fl_q.size(), 32'd0);
    chk("sfence_pending_drained", sf_pend, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
